alu_op_sequencer: RTL and testbench

Bit-serial controller for the 1-bit ALU lane (inputs A, B, select S1/S0, output F). It accepts a WIDTH-bit operand pair and a 2-bit operation code, and drives the lane one bit per cycle, LSB first. It collects each F bit into a result register and reports completion through a start/busy/done handshake. It sits between the register/control logic and the shared ALU lane, so wide operations reuse the single-bit datapath.

---
 rtl/alu_op_sequencer.sv | 107 ++++++++++
 tb/tb_alu_op_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a shared 1-bit ALU lane one bit per cycle
// (LSB first) to perform a WIDTH-bit operation, assembling F into result.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   start, op, a, b request, op code (op[1]=S1, op[0]=S0), operands
//   busy, done      RUN indicator, one-cycle completion pulse
//   result          assembled result, held until next accepted start
//   alu_a/b/s0/s1   lane drive (0 outside RUN); alu_f lane output
//   abort           only when ALU_SEQ_ABORT_EN is defined: cancel RUN
module alu_op_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef ALU_SEQ_ABORT_EN
   input  logic             abort,
`endif
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_s0,
   output logic             alu_s1,
   input  logic             alu_f
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_result;
   logic             w_run;
   logic             w_accept;
   logic             w_abort;

`ifdef ALU_SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_run    = (r_state == S_RUN);
   // IDLE and DONE both accept; start during RUN is dropped
   assign w_accept = start && !w_run;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN: begin
            if (w_abort)            w_next = S_IDLE;
            else if (r_cnt == LAST) w_next = S_DONE;
         end
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_op     <= op;
            r_cnt    <= '0;
            r_result <= '0;
         end else if (w_run) begin
            // the bit on the lane at an abort edge is still kept
            r_result[r_cnt] <= alu_f;
            if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign busy   = w_run;
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign alu_a  = w_run & r_a[r_cnt];
   assign alu_b  = w_run & r_b[r_cnt];
   assign alu_s1 = w_run & r_op[1];
   assign alu_s0 = w_run & r_op[0];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: self-checking bench for alu_op_sequencer with a
// behavioural lane model and a word-level reference for each operation.
module tb_alu_op_sequencer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         alu_a;
   logic         alu_b;
   logic         alu_s0;
   logic         alu_s1;
   logic         alu_f;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // external 1-bit ALU lane: 00 AND, 01 OR, 10 XOR, 11 XNOR
   always_comb begin
      alu_f = 1'b0;
      case ({alu_s1, alu_s0})
         2'b00: alu_f = alu_a & alu_b;
         2'b01: alu_f = alu_a | alu_b;
         2'b10: alu_f = alu_a ^ alu_b;
         2'b11: alu_f = ~(alu_a ^ alu_b);
         default: alu_f = 1'b0;
      endcase
   end

   alu_op_sequencer #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
`ifdef ALU_SEQ_ABORT_EN
      .abort  (abort),
`endif
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alu_s0 (alu_s0),
      .alu_s1 (alu_s1),
      .alu_f  (alu_f)
   );

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [1:0] o);
      case (o)
         2'b00:   return x & y;
         2'b01:   return x | y;
         2'b10:   return x ^ y;
         default: return ~(x ^ y);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      op = '0; a = '0; b = '0;
      tick(); tick();
      n_vec++;
      if ({busy, done, result, alu_a, alu_b, alu_s0, alu_s1} !== '0) begin
         n_err++;
         $display("FAIL reset_vals: got %b want 0",
                  {busy, done, result, alu_a, alu_b, alu_s0, alu_s1});
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_vec++;
         if ({busy, done, result, alu_a, alu_b, alu_s0, alu_s1} !== '0) begin
            n_err++;
            $display("FAIL idle_quiet c%0d: got %b want 0", i,
                     {busy, done, result, alu_a, alu_b, alu_s0, alu_s1});
         end
      end
   endtask

   task automatic test_xor_trace();
      logic [W-1:0] exp_a;
      exp_a = 8'b1010_0101;
      a = 8'hA5; b = 8'h3C; op = 2'b10; start = 1'b1;
      tick();
      start = 1'b0; a = 8'h00; b = 8'hFF;
      for (int i = 0; i < W; i++) begin
         n_vec++;
         if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL xor_busy c%0d: got %b want 10", i + 1, {busy, done});
         end
         n_vec++;
         if ({alu_a, alu_b, alu_s1, alu_s0} !==
             {exp_a[i], 8'h3C >> i & 8'h01 ? 1'b1 : 1'b0, 2'b10}) begin
            n_err++;
            $display("FAIL xor_lane c%0d: got %b want %b", i + 1,
                     {alu_a, alu_b, alu_s1, alu_s0},
                     {exp_a[i], (8'h3C >> i & 8'h01) ? 1'b1 : 1'b0, 2'b10});
         end
         tick();
      end
      n_vec++;
      if ({busy, done, result} !== {2'b01, 8'h99}) begin
         n_err++;
         $display("FAIL xor_done: got %b %b %h want 0 1 99", busy, done, result);
      end
      tick();
      n_vec++;
      if ({busy, done, alu_a, alu_b, alu_s0, alu_s1, result} !==
          {6'b0, 8'h99}) begin
         n_err++;
         $display("FAIL xor_after: got %b %h want 000000 99",
                  {busy, done, alu_a, alu_b, alu_s0, alu_s1}, result);
      end
   endtask

   task automatic test_ops();
      logic [1:0]   ops  [3] = '{2'b00, 2'b01, 2'b11};
      logic [W-1:0] exps [3] = '{8'hC0, 8'hFC, 8'hC3};
      for (int k = 0; k < 3; k++) begin
         a = 8'hF0; b = 8'hCC; op = ops[k]; start = 1'b1;
         tick();
         start = 1'b0;
         repeat (W - 1) tick();
         n_vec++;
         if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL ops_c8 op%b: got %b want 10", ops[k], {busy, done});
         end
         tick();
         n_vec++;
         if ({done, result} !== {1'b1, exps[k]}) begin
            n_err++;
            $display("FAIL ops_res op%b: got %b %h want 1 %h",
                     ops[k], done, result, exps[k]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ea;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      start = 1'b1;
      ea = a;
      tick();
      for (int k = 0; k < 4; k++) begin
         for (int c = 1; c <= W; c++) begin
            n_vec++;
            if ({busy, done} !== 2'b10) begin
               n_err++;
               $display("FAIL b2b_busy op%0d c%0d: got %b want 10",
                        k, c, {busy, done});
            end
            a = W'($urandom);
            tick();
         end
         n_vec++;
         if ({busy, done, result} !== {2'b01, ref_op(ea, b, op)}) begin
            n_err++;
            $display("FAIL b2b_done op%0d: got %b %h want 01 %h",
                     k, {busy, done}, result, ref_op(ea, b, op));
         end
         a = W'($urandom);
         ea = a;
         if (k == 3) start = 1'b0;
         tick();
      end
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL b2b_stop: got %b want 00", {busy, done});
      end
   endtask

   task automatic test_busy_ignore();
      a = 8'h5A; b = 8'hFF; op = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; a = 8'h12; b = 8'h00; op = 2'b01;
      tick();
      start = 1'b0; a = 8'h00;
      repeat (5) tick();
      n_vec++;
      if ({done, result} !== {1'b1, ref_op(8'h5A, 8'hFF, 2'b00)}) begin
         n_err++;
         $display("FAIL ignore_res: got %b %h want 1 %h",
                  done, result, ref_op(8'h5A, 8'hFF, 2'b00));
      end
      tick();
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_err++;
         $display("FAIL ignore_idle: got %b want 00", {busy, done});
      end
   endtask

   task automatic test_reset_mid_run();
      int seen;
      a = 8'hFF; b = 8'hFF; op = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({busy, result} !== {1'b1, 8'h07}) begin
         n_err++;
         $display("FAIL rst_pre: got %b %h want 1 07", busy, result);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if ({busy, done, result, alu_a, alu_b} !== '0) begin
         n_err++;
         $display("FAIL rst_mid: got %b %b %h want 0 0 00", busy, done, result);
      end
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || busy) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL rst_nodone: got %0d active cycles want 0", seen);
      end
      a = 8'hFF; b = 8'h0F; op = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (W) tick();
      n_vec++;
      if ({done, result} !== {1'b1, 8'h0F}) begin
         n_err++;
         $display("FAIL rst_next: got %b %h want 1 0f", done, result);
      end
      tick();
   endtask

`ifdef ALU_SEQ_ABORT_EN
   task automatic test_abort();
      int seen;
      a = 8'hFF; b = 8'hFF; op = 2'b00; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_vec++;
      if ({busy, done, result} !== {2'b00, ref_op(8'hFF, 8'hFF, 2'b00) & 8'h07})
      begin
         n_err++;
         $display("FAIL abort_res: got %b %h want 00 07", {busy, done}, result);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done || busy || result !== 8'h07) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL abort_hold: got %0d bad cycles want 0", seen);
      end
      a = 8'h33; b = 8'hFF; op = 2'b00; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL abort_prio: got busy %b want 1", busy);
      end
      repeat (W) tick();
      n_vec++;
      if ({done, result} !== {1'b1, 8'h33}) begin
         n_err++;
         $display("FAIL abort_next: got %b %h want 1 33", done, result);
      end
      tick();
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic [1:0]   ro;
      for (int k = 0; k < 20; k++) begin
         ra = W'($urandom); rb = W'($urandom); ro = 2'($urandom);
         a = ra; b = rb; op = ro; start = 1'b1;
         tick();
         start = 1'b0;
         a = W'($urandom); b = W'($urandom); op = 2'($urandom);
         repeat (W - 1) tick();
         n_vec++;
         if ({busy, done} !== 2'b10) begin
            n_err++;
            $display("FAIL rnd_c8 #%0d: got %b want 10", k, {busy, done});
         end
         tick();
         n_vec++;
         if ({done, result} !== {1'b1, ref_op(ra, rb, ro)}) begin
            n_err++;
            $display("FAIL rnd_res #%0d: got %b %h want 1 %h",
                     k, done, result, ref_op(ra, rb, ro));
         end
         repeat ($urandom_range(1, 3)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_xor_trace();
      test_ops();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid_run();
`ifdef ALU_SEQ_ABORT_EN
      test_abort();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
